// File: rtl/pattern_store.sv
// pattern_store: DEPTH x WIDTH pattern array with serial scan load, addressed field
// writes and a registered, pointer-streamed field read port.
module pattern_store #(
   parameter int DEPTH = 22,
   parameter int WIDTH = 8,
   parameter int PTR_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ssel,
   input  logic             sin,
   output logic             sout,
   output logic             load_done,
   input  logic             wr_en,
   input  logic [PTR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   output logic             wr_err,
   input  logic             rd_load,
   input  logic [PTR_W-1:0] rd_addr,
   input  logic             rd_inc,
   output logic [PTR_W-1:0] rd_ptr,
   output logic [WIDTH-1:0] field_byte
);
   localparam int N = DEPTH * WIDTH;
   localparam int CW = $clog2(N);
   localparam logic [PTR_W:0] DEP = (PTR_W + 1)'(DEPTH);
   localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
   // Field i occupies flat bits [i*WIDTH +: WIDTH]; the scan chain runs from bit 0 up to bit N-1.
   logic [N-1:0] pat_q, pat_d;
   logic [WIDTH-1:0] fld [DEPTH];
   logic [CW-1:0] cnt_q, cnt_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [WIDTH-1:0] field_q, field_d;
   logic done_q, done_d, err_q, err_d, wr_ok;
   always_comb begin
      wr_ok = wr_en && !ssel && ({1'b0, wr_addr} < DEP);
      pat_d = ssel ? {pat_q[N-2:0], sin} : pat_q;
      for (int i = 0; i < DEPTH; i++) begin
         fld[i] = pat_q[i*WIDTH +: WIDTH];
         if (wr_ok && wr_addr == PTR_W'(i)) pat_d[i*WIDTH +: WIDTH] = wr_data;
      end
      cnt_d = (ssel && cnt_q != CNT_LAST) ? cnt_q + 1'b1 : '0;
      done_d = ssel && cnt_q == CNT_LAST;
      err_d = wr_en && !wr_ok;
      ptr_d = rd_load ? (({1'b0, rd_addr} < DEP) ? rd_addr : '0)
            : rd_inc ? ((ptr_q == LAST) ? '0 : ptr_q + 1'b1)
            : ptr_q;
      field_d = ssel ? field_q : (wr_ok && wr_addr == ptr_q) ? wr_data : fld[ptr_q];
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pat_q <= '0;
         cnt_q <= '0;
         ptr_q <= '0;
         field_q <= '0;
         done_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         pat_q <= pat_d;
         cnt_q <= cnt_d;
         ptr_q <= ptr_d;
         field_q <= field_d;
         done_q <= done_d;
         err_q <= err_d;
      end
   end
   assign sout = pat_q[N-1];
   assign load_done = done_q;
   assign wr_err = err_q;
   assign rd_ptr = ptr_q;
   assign field_byte = field_q;
endmodule

// File: tb/tb_pattern_store.sv
// tb_pattern_store: directed and randomized checks of pattern_store against a
// field-level behavioural model.
module tb_pattern_store;
   localparam int D = 22;
   localparam int W = 8;
   localparam int N = D * W;
   logic clk = 1'b0;
   logic rst_n, ssel, sin, sout, load_done, wr_en, wr_err, rd_load, rd_inc;
   logic [4:0] wr_addr, rd_addr, rd_ptr;
   logic [7:0] wr_data, field_byte;
   int checks = 0, errors = 0, ndone = 0;
   bit [7:0] m [D];
   int mptr, mcnt;
   bit [7:0] mfb;
   bit mdone, merr;
   bit b1 [100];

   always #5 clk = ~clk;

   pattern_store #(.DEPTH(D), .WIDTH(W), .PTR_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .ssel(ssel), .sin(sin), .sout(sout),
      .load_done(load_done), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_err(wr_err), .rd_load(rd_load), .rd_addr(rd_addr), .rd_inc(rd_inc),
      .rd_ptr(rd_ptr), .field_byte(field_byte)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model(input bit r, s, si, we, input int wa, wd, input bit rl, input int ra, input bit ri);
      bit ok, c, nc;
      if (!r) begin
         foreach (m[i]) m[i] = 8'h00;
         mptr = 0; mfb = 0; mcnt = 0; mdone = 0; merr = 0;
      end else begin
         ok = we && !s && wa < D;
         merr = we && !ok;
         if (!s) mfb = (ok && wa == mptr) ? 8'(wd) : m[mptr];
         mptr = rl ? (ra < D ? ra : 0) : ri ? (mptr + 1) % D : mptr;
         if (s) begin
            c = si;
            for (int i = 0; i < D; i++) begin
               nc = m[i][7];
               m[i] = {m[i][6:0], c};
               c = nc;
            end
         end else if (ok) m[wa] = 8'(wd);
         mdone = 0;
         if (s) begin
            mcnt++;
            if (mcnt == N) begin mdone = 1; mcnt = 0; end
         end else mcnt = 0;
      end
   endtask

   task automatic cyc(input bit r, s, si, we, input int wa, wd, input bit rl, input int ra, input bit ri);
      rst_n = r; ssel = s; sin = si; wr_en = we; wr_addr = 5'(wa); wr_data = 8'(wd);
      rd_load = rl; rd_addr = 5'(ra); rd_inc = ri;
      @(posedge clk);
      model(r, s, si, we, wa, wd, rl, ra, ri);
      #1;
      if (load_done === 1'b1) ndone++;
      chk("sout", sout, m[D-1][W-1]);
      chk("field_byte", field_byte, mfb);
      chk("rd_ptr", rd_ptr, mptr);
      chk("load_done", load_done, mdone);
      chk("wr_err", wr_err, merr);
   endtask

   task automatic idle();
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      int v;
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 20; k++)
         cyc(1, $urandom % 2, $urandom % 2, $urandom % 2, $urandom % 32, $urandom % 256,
             $urandom % 2, $urandom % 32, $urandom % 2);
      // reset overrides shift, write and pointer controls
      cyc(0, 1, 1, 1, 3, 8'hff, 1, 4, 1);
      chk("rst_sout", sout, 0);
      chk("rst_field", field_byte, 0);
      chk("rst_ptr", rd_ptr, 0);
      chk("rst_done", load_done, 0);
      chk("rst_err", wr_err, 0);
      cyc(1, 0, 0, 0, 0, 0, 1, 0, 0);
      for (int k = 0; k < D; k++) begin
         cyc(1, 0, 0, 0, 0, 0, 0, 0, 1);
         chk("rst_array", field_byte, 0);
      end
      ndone = 0;
      for (int k = 0; k < N; k++) begin
         v = (D - 1 - k / W) + 8'h10;
         cyc(1, 1, v[7 - k % W], 0, 0, 0, 0, 0, 0);
         chk("load_done_at", load_done, k == N - 1);
      end
      chk("load_done_count", ndone, 1);
      cyc(1, 0, 0, 0, 0, 0, 1, 0, 0);
      for (int k = 0; k < 24; k++) begin
         cyc(1, 0, 0, 0, 0, 0, 0, 0, 1);
         chk("stream", field_byte, 8'h10 + k % D);
      end
      for (int e = 0; e < 100; e++) begin
         b1[e] = 1'($urandom % 2);
         cyc(1, 1, b1[e], 0, 0, 0, 0, 0, 0);
      end
      idle();
      ndone = 0;
      for (int e = 1; e <= N; e++) begin
         cyc(1, 1, $urandom % 2, 0, 0, 0, 0, 0, 0);
         chk("abort_done", load_done, e == N);
         if (e >= 76) chk("sout_order", sout, b1[e - 76]);
      end
      chk("abort_done_count", ndone, 1);
      cyc(1, 0, 0, 0, 0, 0, 1, 5, 0);
      cyc(1, 0, 0, 1, 5, 8'hA5, 0, 0, 0);
      chk("bypass", field_byte, 8'hA5);
      cyc(1, 0, 0, 1, 6, 8'h3C, 0, 0, 0);
      chk("no_bypass", field_byte, 8'hA5);
      cyc(1, 0, 0, 0, 0, 0, 1, 6, 0);
      idle();
      chk("wr6", field_byte, 8'h3C);
      cyc(1, 0, 0, 1, 22, 8'h77, 0, 0, 0);
      chk("err_range", wr_err, 1);
      idle();
      chk("err_pulse", wr_err, 0);
      chk("err_unchanged", field_byte, 8'h3C);
      cyc(1, 1, 1, 1, 3, 8'h55, 0, 0, 0);
      chk("err_ssel", wr_err, 1);
      cyc(1, 0, 0, 0, 0, 0, 1, 30, 0);
      chk("load_oob", rd_ptr, 0);
      cyc(1, 0, 0, 0, 0, 0, 1, 7, 1);
      chk("load_prio", rd_ptr, 7);
      cyc(1, 0, 0, 0, 0, 0, 1, 21, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 1);
      chk("inc_wrap", rd_ptr, 0);
      for (int k = 0; k < 1500; k++)
         cyc(($urandom % 100) != 0, ($urandom % 3) == 0, $urandom % 2, $urandom % 2,
             $urandom % 32, $urandom % 256, ($urandom % 5) == 0, $urandom % 32, $urandom % 2);
      for (int k = 0; k < 600; k++)
         cyc(($urandom % 500) != 0, ($urandom % 300) != 0, $urandom % 2, $urandom % 2,
             $urandom % 32, $urandom % 256, ($urandom % 5) == 0, $urandom % 32, $urandom % 2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
